// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage bundle between the decode pipeline and the forwarding/hazard scoreboard.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 16
);

  logic                      fwd_en_i;
  logic                      freeze_i;
  logic                      flush_i;
  logic                      id_valid_i;
  logic [NUM_SRC*REG_AW-1:0] id_src_i;
  logic [NUM_SRC-1:0]        id_src_used_i;
  logic [REG_AW-1:0]         id_dest_i;
  logic                      id_wb_en_i;
  logic                      id_mem_read_i;
  logic                      hazard_o;
  logic [NUM_SRC*SEL_W-1:0]  sel_src_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  // Pipeline control / decode side
  modport master (
    output fwd_en_i, freeze_i, flush_i, id_valid_i, id_src_i, id_src_used_i,
           id_dest_i, id_wb_en_i, id_mem_read_i,
    input  hazard_o, sel_src_o, stall_cnt_o
  );

  // Scoreboard side
  modport slave (
    input  fwd_en_i, freeze_i, flush_i, id_valid_i, id_src_i, id_src_used_i,
           id_dest_i, id_wb_en_i, id_mem_read_i,
    output hazard_o, sel_src_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding + hazard unit: tracks in-flight writers in a DEPTH-entry
// destination shift register (stage 0 = EXE ... stage DEPTH-1 = WB),
// registers per-source forward selects for the instruction entering EXE,
// raises a combinational stall on load-use (or any RAW when forwarding is
// off), and keeps a saturating stall-cycle counter.
// DEPTH must be >= 2 and 2**SEL_W must be >= DEPTH.
module fwd_hazard_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst,
  fwd_hazard_scoreboard_if.slave bus
);

  // WB is write-first into the regfile, so only stages 0..DEPTH-2 forward.
  localparam int unsigned FWD_STAGES = DEPTH - 1;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic [REG_AW-1:0] dest;
  } entry_t;

  entry_t                   stage_q [DEPTH];
  entry_t                   stage_d [DEPTH];
  logic [NUM_SRC*SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [FWD_STAGES-1:0]    match [NUM_SRC];
  logic                     load_use;
  logic                     raw_any;
  logic                     hazard;
  logic                     issue;

  // Source-vs-producer compare for every source and every forwarding stage
  always_comb begin
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      for (int j = 0; j < int'(FWD_STAGES); j++) begin
        match[k][j] = bus.id_valid_i
                    & bus.id_src_used_i[k]
                    & stage_q[j].valid
                    & stage_q[j].wb_en
                    & (bus.id_src_i[k*REG_AW +: REG_AW] == stage_q[j].dest);
      end
    end
  end

  // Stall decision; independent of freeze/flush so ID sees it immediately
  always_comb begin
    load_use = 1'b0;
    raw_any  = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      load_use = load_use | (match[k][0] & stage_q[0].mem_read);
      raw_any  = raw_any  | (|match[k]);
    end
    hazard = bus.fwd_en_i ? load_use : raw_any;
    issue  = bus.id_valid_i & ~hazard & ~bus.flush_i;
  end

  // Next-state: advance the tracker, pick forward selects, count stalls
  always_comb begin
    for (int j = 0; j < int'(DEPTH); j++) begin
      stage_d[j] = stage_q[j];
    end
    sel_d = sel_q;
    cnt_d = cnt_q;

    if (!bus.freeze_i) begin
      for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
        stage_d[j] = stage_q[j-1];
      end

      stage_d[0] = '0;
      if (issue) begin
        stage_d[0].valid    = 1'b1;
        stage_d[0].wb_en    = bus.id_wb_en_i;
        stage_d[0].mem_read = bus.id_mem_read_i;
        stage_d[0].dest     = bus.id_dest_i;
      end

      // Scan oldest-to-youngest so the youngest (lowest j) producer wins;
      // the producer moves one stage on while the consumer enters EXE.
      sel_d = '0;
      if (bus.fwd_en_i && issue) begin
        for (int k = 0; k < int'(NUM_SRC); k++) begin
          for (int j = int'(FWD_STAGES) - 1; j >= 0; j--) begin
            if (match[k][j]) begin
              sel_d[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
            end
          end
        end
      end

      if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        stage_q[j] <= '0;
      end
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        stage_q[j] <= stage_d[j];
      end
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.hazard_o    = hazard;
  assign bus.sel_src_o   = sel_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule
